// File: rtl/sm4_word_packer_pkg.sv
// rtl/sm4_word_packer_pkg.sv - shared SM4 widths, packer state encoding and standard test vectors
package sm4_pkg;

    localparam int SM4_WORD_W        = 32;
    localparam int SM4_BLK_W         = 128;
    localparam int SM4_WORDS_PER_BLK = 4;

    typedef enum logic {
        COLLECT  = 1'b0,
        KEY_WAIT = 1'b1
    } packer_state_t;

    // GB/T 32907 example: key and plaintext share the same value.
    localparam logic [SM4_BLK_W-1:0] SM4_TV_KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [SM4_BLK_W-1:0] SM4_TV_PT  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [SM4_BLK_W-1:0] SM4_TV_CT  = 128'h681edf34d206965e86b3e94f536e4246;

endpackage

// File: rtl/sm4_word_packer_if.sv
// rtl/sm4_word_packer_if.sv - word stream in, key/data blocks out, with source and packer views
interface sm4_word_packer_if;
    import sm4_pkg::*;

    logic [SM4_WORD_W-1:0] WORD_i;
    logic                  WORD_VALID_i;
    logic                  WORD_KEY_i;
    logic                  WORD_READY_o;
    logic [SM4_BLK_W-1:0]  MK_o;
    logic                  MK_VALID_o;
    logic [SM4_BLK_W-1:0]  DAT_o;
    logic                  DAT_VALID_o;
    logic                  KEY_LOADED_o;
    logic                  ERR_o;

    modport master (
        output WORD_i, WORD_VALID_i, WORD_KEY_i,
        input  WORD_READY_o, MK_o, MK_VALID_o, DAT_o, DAT_VALID_o, KEY_LOADED_o, ERR_o
    );

    modport slave (
        input  WORD_i, WORD_VALID_i, WORD_KEY_i,
        output WORD_READY_o, MK_o, MK_VALID_o, DAT_o, DAT_VALID_o, KEY_LOADED_o, ERR_o
    );

endinterface

// File: rtl/sm4_word_packer.sv
// rtl/sm4_word_packer.sv - packs 32-bit words into 128-bit SM4 keys/blocks and holds off input during key expansion
module sm4_word_packer
    import sm4_pkg::*;
#(
    parameter int KEYEXP_LATENCY = 32,
    parameter bit REQUIRE_KEY    = 1'b1
) (
    input  logic               CLK_i,
    input  logic               RST_i,
    sm4_word_packer_if.slave   bus
);

    packer_state_t                   state_q, state_n;
    logic [1:0]                      cnt_q, cnt_n;
    logic                            blk_key_q, blk_key_n;
    logic [SM4_BLK_W-SM4_WORD_W-1:0] shreg_q, shreg_n;
    logic [7:0]                      wait_q, wait_n;
    logic                            ready_q, ready_n;
    logic [SM4_BLK_W-1:0]            mk_q, mk_n;
    logic                            mk_valid_q, mk_valid_n;
    logic [SM4_BLK_W-1:0]            dat_q, dat_n;
    logic                            dat_valid_q, dat_valid_n;
    logic                            key_loaded_q, key_loaded_n;
    logic                            err_q, err_n;

    logic                            accept;
    logic                            mismatch;
    logic [SM4_BLK_W-1:0]            full_blk;

    assign accept   = bus.WORD_VALID_i & ready_q;
    assign mismatch = (cnt_q != 2'd0) && (bus.WORD_KEY_i != blk_key_q);
    assign full_blk = {shreg_q, bus.WORD_i};

    // Next-state and next-output logic; the ready flag follows the next state so it is registered.
    always_comb begin
        state_n      = state_q;
        cnt_n        = cnt_q;
        blk_key_n    = blk_key_q;
        shreg_n      = shreg_q;
        wait_n       = wait_q;
        mk_n         = mk_q;
        mk_valid_n   = 1'b0;
        dat_n        = dat_q;
        dat_valid_n  = 1'b0;
        key_loaded_n = key_loaded_q;
        err_n        = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (cnt_q == 2'd0 || mismatch) begin
                        // A type change restarts the block with the offending word as its first word.
                        err_n                   = mismatch;
                        blk_key_n               = bus.WORD_KEY_i;
                        shreg_n[95:64]          = bus.WORD_i;
                        cnt_n                   = 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        shreg_n[63:32]          = bus.WORD_i;
                        cnt_n                   = 2'd2;
                    end else if (cnt_q == 2'd2) begin
                        shreg_n[31:0]           = bus.WORD_i;
                        cnt_n                   = 2'd3;
                    end else begin
                        cnt_n = 2'd0;
                        if (blk_key_q) begin
                            mk_n         = full_blk;
                            mk_valid_n   = 1'b1;
                            key_loaded_n = 1'b1;
                            state_n      = KEY_WAIT;
                            wait_n       = 8'(KEYEXP_LATENCY);
                        end else if (REQUIRE_KEY && !key_loaded_q) begin
                            err_n = 1'b1;
                        end else begin
                            dat_n       = full_blk;
                            dat_valid_n = 1'b1;
                        end
                    end
                end
            end
            KEY_WAIT: begin
                // The last wait cycle releases ready at the following edge.
                if (wait_q <= 8'd1) begin
                    state_n = COLLECT;
                    wait_n  = 8'd0;
                end else begin
                    wait_n = wait_q - 8'd1;
                end
            end
            default: state_n = COLLECT;
        endcase

        ready_n = (state_n == COLLECT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q      <= COLLECT;
            cnt_q        <= 2'd0;
            blk_key_q    <= 1'b0;
            shreg_q      <= '0;
            wait_q       <= 8'd0;
            ready_q      <= 1'b0;
            mk_q         <= '0;
            mk_valid_q   <= 1'b0;
            dat_q        <= '0;
            dat_valid_q  <= 1'b0;
            key_loaded_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            blk_key_q    <= blk_key_n;
            shreg_q      <= shreg_n;
            wait_q       <= wait_n;
            ready_q      <= ready_n;
            mk_q         <= mk_n;
            mk_valid_q   <= mk_valid_n;
            dat_q        <= dat_n;
            dat_valid_q  <= dat_valid_n;
            key_loaded_q <= key_loaded_n;
            err_q        <= err_n;
        end
    end

    assign bus.WORD_READY_o = ready_q;
    assign bus.MK_o         = mk_q;
    assign bus.MK_VALID_o   = mk_valid_q;
    assign bus.DAT_o        = dat_q;
    assign bus.DAT_VALID_o  = dat_valid_q;
    assign bus.KEY_LOADED_o = key_loaded_q;
    assign bus.ERR_o        = err_q;

endmodule

// File: tb/tb_sm4_word_packer.sv
// tb/tb_sm4_word_packer.sv - directed self-checking bench for sm4_word_packer
module tb_sm4_word_packer;
    import sm4_pkg::*;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic [31:0] w0, w1;
    logic        v0, v1, k0, k1;
    int          errors = 0;
    int          checks = 0;
    int          low;

    always #5 clk = ~clk;

    sm4_word_packer_if intf0 ();
    sm4_word_packer_if intf1 ();

    assign intf0.WORD_i       = w0;
    assign intf0.WORD_VALID_i = v0;
    assign intf0.WORD_KEY_i   = k0;
    assign intf1.WORD_i       = w1;
    assign intf1.WORD_VALID_i = v1;
    assign intf1.WORD_KEY_i   = k1;

    sm4_word_packer #(.KEYEXP_LATENCY(32), .REQUIRE_KEY(1'b1)) dut0 (
        .CLK_i (clk),
        .RST_i (rst0),
        .bus   (intf0.slave)
    );

    sm4_word_packer #(.KEYEXP_LATENCY(4), .REQUIRE_KEY(1'b0)) dut1 (
        .CLK_i (clk),
        .RST_i (rst1),
        .bus   (intf1.slave)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? intf0.WORD_READY_o : intf1.WORD_READY_o;
    endfunction

    // Present a word at a negedge, wait until it is accepted, return at the negedge after the accepting edge.
    task automatic put(input int d, input logic [31:0] w, input logic k);
        int n = 0;
        if (d == 0) begin w0 = w; k0 = k; v0 = 1'b1; end
        else        begin w1 = w; k1 = k; v1 = 1'b1; end
        while (!rdy(d) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $error("FAIL put_timeout: observed ready=0 for %0d cycles required ready=1", n);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int d);
        if (d == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        w0 = '0; w1 = '0; v0 = 1'b0; v1 = 1'b0; k0 = 1'b0; k1 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values on dut0.
        chk("rst_ready", 128'(intf0.WORD_READY_o), 128'd0);
        chk("rst_mk",    intf0.MK_o,               128'd0);
        chk("rst_dat",   intf0.DAT_o,              128'd0);
        chk("rst_kl",    128'(intf0.KEY_LOADED_o), 128'd0);
        chk("rst_err",   128'(intf0.ERR_o),        128'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 128'(intf0.WORD_READY_o), 128'd1);

        // Data block with no key loaded is dropped.
        put(0, 32'h11111111, 1'b0);
        put(0, 32'h22222222, 1'b0);
        put(0, 32'h33333333, 1'b0);
        put(0, 32'h44444444, 1'b0);
        idle(0);
        chk("nokey_dat_valid", 128'(intf0.DAT_VALID_o), 128'd0);
        chk("nokey_err",       128'(intf0.ERR_o),       128'd1);
        chk("nokey_dat",       intf0.DAT_o,             128'd0);
        @(negedge clk);
        chk("nokey_err_single", 128'(intf0.ERR_o), 128'd0);

        // Two data words, then a key word restarts the block as a key.
        put(0, 32'haaaaaaaa, 1'b0);
        put(0, 32'hbbbbbbbb, 1'b0);
        chk("mm_no_err_yet", 128'(intf0.ERR_o), 128'd0);
        put(0, 32'h01234567, 1'b1);
        chk("mm_err", 128'(intf0.ERR_o), 128'd1);
        put(0, 32'h89abcdef, 1'b1);
        chk("mm_err_single", 128'(intf0.ERR_o), 128'd0);
        put(0, 32'hfedcba98, 1'b1);
        put(0, 32'h76543210, 1'b1);
        chk("key_mk",        intf0.MK_o,               SM4_TV_KEY);
        chk("key_mk_valid",  128'(intf0.MK_VALID_o),   128'd1);
        chk("key_loaded",    128'(intf0.KEY_LOADED_o), 128'd1);
        chk("key_dat_valid", 128'(intf0.DAT_VALID_o),  128'd0);
        chk("key_ready_low", 128'(intf0.WORD_READY_o), 128'd0);

        // Source keeps presenting the first data word through the whole wait.
        w0 = 32'h01234567; k0 = 1'b0; v0 = 1'b1;
        @(negedge clk);
        chk("mk_valid_single", 128'(intf0.MK_VALID_o), 128'd0);
        low = 1;
        while (!intf0.WORD_READY_o && low < 100) begin
            @(negedge clk);
            low++;
        end
        chk("keywait_len", 128'(low), 128'd32);

        put(0, 32'h01234567, 1'b0);
        put(0, 32'h89abcdef, 1'b0);
        put(0, 32'hfedcba98, 1'b0);
        put(0, 32'h76543210, 1'b0);
        idle(0);
        chk("dat_tv",        intf0.DAT_o,             SM4_TV_PT);
        chk("dat_valid",     128'(intf0.DAT_VALID_o), 128'd1);
        chk("dat_no_err",    128'(intf0.ERR_o),       128'd0);
        chk("dat_no_mk_vld", 128'(intf0.MK_VALID_o),  128'd0);
        @(negedge clk);
        chk("dat_valid_single", 128'(intf0.DAT_VALID_o), 128'd0);
        chk("mk_held",          intf0.MK_o,              SM4_TV_KEY);

        // dut1: reset in the middle of a block discards the partial words.
        put(1, 32'hdeadbeef, 1'b0);
        put(1, 32'hcafef00d, 1'b0);
        put(1, 32'h55555555, 1'b0);
        idle(1);
        rst1 = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 128'(intf1.WORD_READY_o), 128'd0);
        chk("mid_rst_dat",   intf1.DAT_o,              128'd0);
        chk("mid_rst_err",   128'(intf1.ERR_o),        128'd0);
        rst1 = 1'b0;
        @(negedge clk);
        put(1, 32'h10203040, 1'b0);
        put(1, 32'h50607080, 1'b0);
        put(1, 32'h90a0b0c0, 1'b0);
        put(1, 32'hd0e0f000, 1'b0);
        idle(1);
        chk("fresh_dat",       intf1.DAT_o,             128'h102030405060708090a0b0c0d0e0f000);
        chk("fresh_dat_valid", 128'(intf1.DAT_VALID_o), 128'd1);
        chk("fresh_no_err",    128'(intf1.ERR_o),       128'd0);

        // dut1: short key-expansion window.
        put(1, 32'h00000001, 1'b1);
        put(1, 32'h00000002, 1'b1);
        put(1, 32'h00000003, 1'b1);
        put(1, 32'h00000004, 1'b1);
        idle(1);
        chk("k1_mk", intf1.MK_o, 128'h00000001000000020000000300000004);
        low = 0;
        while (!intf1.WORD_READY_o && low < 100) begin
            @(negedge clk);
            low++;
        end
        chk("k1_wait_len", 128'(low), 128'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
